bcd_entry_decoder: RTL and testbench

BCD_ENTRY_DECODER -- requirements
Module: bcd_entry_decoder

---
 rtl/bcd_entry_decoder_pkg.sv | 19 +
 rtl/bcd_entry_decoder_pair.sv | 14 +
 rtl/bcd_entry_decoder.sv | 159 +++++++++++++++
 tb/tb_bcd_entry_decoder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_entry_decoder_pkg.sv
// Shared definitions for the two-digit BCD entry decoder: FSM states,
// error cause codes and the largest legal BCD digit.
package bcd_entry_decoder_pkg;

    typedef enum logic [1:0] {
        S_TENS = 2'd0,
        S_ONES = 2'd1,
        S_CALC = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_DIGIT   = 2'b01;
    localparam logic [1:0] ERR_RANGE   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

endpackage

// File: rtl/bcd_entry_decoder_pair.sv
// Combinational tens*10 + ones using shifts and adds only.
// Largest input pair (9,9) gives 99, which fits the 7-bit result.
module bcd_pair_to_bin (
    input  logic [3:0] tens_i,
    input  logic [3:0] ones_i,
    output logic [6:0] bin_o
);

    logic [6:0] tens7;

    assign tens7 = {3'b000, tens_i};
    assign bin_o = (tens7 << 3) + (tens7 << 1) + {3'b000, ones_i};

endmodule

// File: rtl/bcd_entry_decoder.sv
// Two-digit BCD entry decoder: collects a tens then a ones digit, converts
// to binary, range-checks against MAX_VAL and reports a value or an error.
module bcd_entry_decoder
    import bcd_entry_decoder_pkg::*;
#(
    parameter int MAX_VAL = 59,
    parameter int TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit_in,
    input  logic       digit_valid,
    output logic       digit_ready,
    input  logic       clear,
    output logic [5:0] val_out,
    output logic       val_valid,
    output logic       err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int             CNT_W    = $clog2(TIMEOUT + 1);
    // Timeout fires on the TIMEOUT-th idle cycle, i.e. when the count already
    // holds TIMEOUT-1 and yet another cycle passes without a digit.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [6:0]     MAX_SUM  = 7'(MAX_VAL);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       ones_q, ones_d;
    logic [6:0]       sum_q, sum_d;
    logic [6:0]       sum_w;
    logic [5:0]       val_q, val_d;
    logic             vv_q, vv_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;
    logic             busy_q, busy_d;
    logic             accept;
    logic             digit_ok;

    assign digit_ready = ((state_q == S_TENS) || (state_q == S_ONES)) && !clear;
    assign accept      = digit_valid && digit_ready;
    assign digit_ok    = (digit_in <= BCD_MAX_DIGIT);

    bcd_pair_to_bin u_pair (
        .tens_i (tens_q),
        .ones_i (ones_q),
        .bin_o  (sum_w)
    );

    // Next-state, datapath and one-cycle output pulses; clear overrides all.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        sum_d   = sum_q;
        val_d   = val_q;
        vv_d    = 1'b0;
        err_d   = 1'b0;
        code_d  = ERR_NONE;
        if (clear) begin
            state_d = S_TENS;
            cnt_d   = '0;
            tens_d  = '0;
            ones_d  = '0;
        end else begin
            case (state_q)
                S_TENS: begin
                    if (accept) begin
                        if (digit_ok) begin
                            tens_d  = digit_in;
                            cnt_d   = '0;
                            state_d = S_ONES;
                        end else begin
                            err_d  = 1'b1;
                            code_d = ERR_DIGIT;
                        end
                    end
                end
                S_ONES: begin
                    if (accept) begin
                        cnt_d = '0;
                        if (digit_ok) begin
                            ones_d  = digit_in;
                            state_d = S_CALC;
                        end else begin
                            err_d   = 1'b1;
                            code_d  = ERR_DIGIT;
                            tens_d  = '0;
                            state_d = S_TENS;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        err_d   = 1'b1;
                        code_d  = ERR_TIMEOUT;
                        tens_d  = '0;
                        cnt_d   = '0;
                        state_d = S_TENS;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_CALC: begin
                    sum_d   = sum_w;
                    state_d = S_OUT;
                end
                S_OUT: begin
                    if (sum_q <= MAX_SUM) begin
                        val_d = sum_q[5:0];
                        vv_d  = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                        code_d = ERR_RANGE;
                    end
                    tens_d  = '0;
                    ones_d  = '0;
                    state_d = S_TENS;
                end
                default: state_d = S_TENS;
            endcase
        end
        busy_d = (state_d != S_TENS);
    end

    // State and registered outputs; reset abandons any entry silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_TENS;
            cnt_q   <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            sum_q   <= '0;
            val_q   <= '0;
            vv_q    <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            sum_q   <= sum_d;
            val_q   <= val_d;
            vv_q    <= vv_d;
            err_q   <= err_d;
            code_q  <= code_d;
            busy_q  <= busy_d;
        end
    end

    assign val_out   = val_q;
    assign val_valid = vv_q;
    assign err       = err_q;
    assign err_code  = code_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_bcd_entry_decoder.sv
// Bench for bcd_entry_decoder: two instances (MAX_VAL 59 and 63, TIMEOUT 4)
// share one stimulus; each entry's outcome is predicted from the digit rules.
module tb_bcd_entry_decoder;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] digit_in = 4'd0;
    logic       digit_valid = 1'b0;
    logic       clear = 1'b0;

    logic       rdy  [2];
    logic [5:0] val  [2];
    logic       vv   [2];
    logic       errs [2];
    logic [1:0] code [2];
    logic       bsy  [2];

    int checks = 0;
    int failures = 0;
    int exp_val [2] = '{0, 0};
    int maxv    [2] = '{59, 63};

    always #5 clk = ~clk;

    bcd_entry_decoder #(.MAX_VAL(59), .TIMEOUT(TO)) dut_a (
        .clk(clk), .rst_n(rst_n), .digit_in(digit_in), .digit_valid(digit_valid),
        .digit_ready(rdy[0]), .clear(clear), .val_out(val[0]), .val_valid(vv[0]),
        .err(errs[0]), .err_code(code[0]), .busy(bsy[0])
    );

    bcd_entry_decoder #(.MAX_VAL(63), .TIMEOUT(TO)) dut_b (
        .clk(clk), .rst_n(rst_n), .digit_in(digit_in), .digit_valid(digit_valid),
        .digit_ready(rdy[1]), .clear(clear), .val_out(val[1]), .val_valid(vv[1]),
        .err(errs[1]), .err_code(code[1]), .busy(bsy[1])
    );

    task automatic chk(input string tag, input int k, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, k, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one digit, confirm it will be taken, clock it in.
    task automatic send(input string tag, input int d);
        digit_in    = 4'(d);
        digit_valid = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) chk({tag, "_rdy"}, k, int'(rdy[k]), 1);
        @(posedge clk);
        #1;
        digit_valid = 1'b0;
        digit_in    = 4'($urandom_range(0, 15));
    endtask

    task automatic quiet(input string tag, input int busy_e);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_vv"},   k, int'(vv[k]),   0);
            chk({tag, "_err"},  k, int'(errs[k]), 0);
            chk({tag, "_code"}, k, int'(code[k]), 0);
            chk({tag, "_val"},  k, int'(val[k]),  exp_val[k]);
            chk({tag, "_busy"}, k, int'(bsy[k]),  busy_e);
        end
    endtask

    task automatic err_pulse(input string tag, input int c);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_vv"},   k, int'(vv[k]),   0);
            chk({tag, "_err"},  k, int'(errs[k]), 1);
            chk({tag, "_code"}, k, int'(code[k]), c);
            chk({tag, "_val"},  k, int'(val[k]),  exp_val[k]);
            chk({tag, "_busy"}, k, int'(bsy[k]),  0);
        end
    endtask

    // Decimal result of the pair, accepted if it fits that instance's limit.
    task automatic result(input string tag, input int t, input int o);
        int s;
        s = t * 10 + o;
        for (int k = 0; k < 2; k++) begin
            if (s <= maxv[k]) begin
                exp_val[k] = s;
                chk({tag, "_vv"},   k, int'(vv[k]),   1);
                chk({tag, "_err"},  k, int'(errs[k]), 0);
                chk({tag, "_code"}, k, int'(code[k]), 0);
            end else begin
                chk({tag, "_vv"},   k, int'(vv[k]),   0);
                chk({tag, "_err"},  k, int'(errs[k]), 1);
                chk({tag, "_code"}, k, int'(code[k]), 2);
            end
            chk({tag, "_val"},  k, int'(val[k]), exp_val[k]);
            chk({tag, "_busy"}, k, int'(bsy[k]), 0);
        end
    endtask

    // One full entry: tens, gap idle cycles, ones, then outcome two edges later.
    task automatic entry(input string tag, input int t, input int o, input int gap);
        send({tag, "_t"}, t);
        if (t > 9) begin
            err_pulse({tag, "_badt"}, 1);
            return;
        end
        quiet({tag, "_held"}, 1);
        for (int i = 1; i <= gap; i++) begin
            tick();
            if (i == TO) begin
                err_pulse({tag, "_tmo"}, 3);
                return;
            end
            quiet({tag, "_idle"}, 1);
        end
        send({tag, "_o"}, o);
        if (o > 9) begin
            err_pulse({tag, "_bado"}, 1);
            return;
        end
        quiet({tag, "_calc"}, 1);
        tick();
        quiet({tag, "_out"}, 1);
        tick();
        result({tag, "_res"}, t, o);
        tick();
        quiet({tag, "_after"}, 0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        quiet("reset", 0);
        for (int k = 0; k < 2; k++) chk("reset_rdy", k, int'(rdy[k]), 1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        entry("s42", 4, 2, 0);
        entry("s63", 6, 3, 0);
        entry("sB", 11, 0, 0);
        entry("s07", 0, 7, 0);
        entry("tmo", 5, 0, TO);
        entry("last", 5, 1, TO - 1);
        entry("bado", 2, 12, 1);
        entry("s99", 9, 9, 2);
        entry("s00", 0, 0, 0);

        // Clear wins over a simultaneous ones digit.
        send("clr_t", 3);
        quiet("clr_held", 1);
        digit_in    = 4'd9;
        digit_valid = 1'b1;
        clear       = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) chk("clr_rdy", k, int'(rdy[k]), 0);
        tick();
        clear       = 1'b0;
        digit_valid = 1'b0;
        quiet("clr_done", 0);
        tick();
        quiet("clr_idle", 0);
        entry("s15", 1, 5, 0);

        // Reset while the conversion is pending.
        send("rst_t", 2);
        send("rst_o", 8);
        quiet("rst_calc", 1);
        rst_n = 1'b0;
        exp_val[0] = 0;
        exp_val[1] = 0;
        #1;
        quiet("rst_now", 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            quiet("rst_after", 0);
        end
        entry("rst_first", 3, 1, 0);

        for (int n = 0; n < 40; n++) begin
            int t, o, g;
            t = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
            o = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
            g = ($urandom_range(0, 5) == 0) ? TO + 1 : int'($urandom_range(0, TO - 1));
            entry("rand", t, o, g);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
